// File: rtl/display_pkg.sv
// Shared definitions for the display sequencing controller: widths,
// FSM encoding and the last-iteration count of the double-dabble loop.
package display_pkg;

  localparam int DATA_W = 8;
  localparam int BCD_W  = 10;
  localparam int CNT_W  = 3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CONVERT = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = 3'd7;

  // Packs the three decimal fields into the working-register layout {H,T,U}.
  function automatic logic [BCD_W-1:0] pack_bcd(input logic [1:0] hundreds,
                                                input logic [3:0] tens,
                                                input logic [3:0] units);
    return {hundreds, tens, units};
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/display_controller.sv
// Sequencing controller in front of the display decoder. Captures an ALU
// result and its flags on start, converts the result to BCD one bit per
// clock, and only then updates the digit and flag outputs.
module display_controller #(
  parameter int DATA_W = display_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              clear,
  input  logic [DATA_W-1:0] Result,
  input  logic              Zero_in,
  input  logic              Overflow_in,
  input  logic              Carry_in,
  output logic [3:0]        Units,
  output logic [3:0]        Tens,
  output logic [1:0]        Hundreds,
  output logic              Zero,
  output logic              Overflow,
  output logic              Carry_out,
  output logic              busy,
  output logic              done
);

  import display_pkg::*;

  // Hundreds is only two bits wide, so any result wider than 8 bits could
  // not be displayed; refuse to elaborate in that case.
  if (DATA_W != 8) begin : g_bad_width
    $error("display_controller: DATA_W must be 8");
  end

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               zero_sh_q, zero_sh_d;
  logic               ovf_sh_q, ovf_sh_d;
  logic               carry_sh_q, carry_sh_d;
  logic [3:0]         units_q, units_d;
  logic [3:0]         tens_q, tens_d;
  logic [1:0]         hundreds_q, hundreds_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               carry_q, carry_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [3:0]         units_adj_s;
  logic [3:0]         tens_adj_s;
  logic [BCD_W-1:0]   bcd_corr_s;
  logic [BCD_W-1:0]   bcd_step_s;

  bcd_add3 u_add3_units (
    .digit_i (bcd_q[3:0]),
    .digit_o (units_adj_s)
  );

  bcd_add3 u_add3_tens (
    .digit_i (bcd_q[7:4]),
    .digit_o (tens_adj_s)
  );

  // The hundreds field never reaches 5 for an 8-bit input, so it is not
  // corrected; its top bit is still zero before the final shift.
  assign bcd_corr_s = pack_bcd(bcd_q[9:8], tens_adj_s, units_adj_s);
  assign bcd_step_s = {bcd_corr_s[BCD_W-2:0], shift_q[DATA_W-1]};

  // Next-state and datapath decisions; clear overrides everything else.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    zero_sh_d  = zero_sh_q;
    ovf_sh_d   = ovf_sh_q;
    carry_sh_d = carry_sh_q;
    units_d    = units_q;
    tens_d     = tens_q;
    hundreds_d = hundreds_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    carry_d    = carry_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (clear) begin
      state_d    = ST_IDLE;
      shift_d    = '0;
      bcd_d      = '0;
      cnt_d      = '0;
      zero_sh_d  = 1'b0;
      ovf_sh_d   = 1'b0;
      carry_sh_d = 1'b0;
      units_d    = 4'd0;
      tens_d     = 4'd0;
      hundreds_d = 2'd0;
      zero_d     = 1'b0;
      ovf_d      = 1'b0;
      carry_d    = 1'b0;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            shift_d    = Result;
            bcd_d      = '0;
            cnt_d      = '0;
            zero_sh_d  = Zero_in;
            ovf_sh_d   = Overflow_in;
            carry_sh_d = Carry_in;
            busy_d     = 1'b1;
            state_d    = ST_CONVERT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CONVERT: begin
          bcd_d   = bcd_step_s;
          shift_d = {shift_q[DATA_W-2:0], 1'b0};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == LAST_CNT) begin
            units_d    = bcd_step_s[3:0];
            tens_d     = bcd_step_s[7:4];
            hundreds_d = bcd_step_s[9:8];
            zero_d     = zero_sh_q;
            ovf_d      = ovf_sh_q;
            carry_d    = carry_sh_q;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_CONVERT;
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Working registers, shadow flags and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      zero_sh_q  <= 1'b0;
      ovf_sh_q   <= 1'b0;
      carry_sh_q <= 1'b0;
      units_q    <= 4'd0;
      tens_q     <= 4'd0;
      hundreds_q <= 2'd0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      carry_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      zero_sh_q  <= zero_sh_d;
      ovf_sh_q   <= ovf_sh_d;
      carry_sh_q <= carry_sh_d;
      units_q    <= units_d;
      tens_q     <= tens_d;
      hundreds_q <= hundreds_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
      carry_q    <= carry_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign Units     = units_q;
  assign Tens      = tens_q;
  assign Hundreds  = hundreds_q;
  assign Zero      = zero_q;
  assign Overflow  = ovf_q;
  assign Carry_out = carry_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
